// File: rtl/xnor_conv_sched_pkg.sv
// Shared constants, FSM state type and popcount-to-dot-product helpers for
// the XNOR convolution scheduler.
package xnor_pkg;

  localparam int K_BITS = 25;
  localparam int CNT_W  = 6;
  localparam int RES_W  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // The PE popcount field can encode more than K_BITS; clamp before use.
  function automatic logic [RES_W-1:0] pop_clamp(input logic [CNT_W-1:0] c);
    logic [RES_W-1:0] ce;
    ce = RES_W'(c);
    return (ce > RES_W'(K_BITS)) ? RES_W'(K_BITS) : ce;
  endfunction

  function automatic logic [RES_W-1:0] pop_to_dot(input logic [CNT_W-1:0] c);
    return (pop_clamp(c) << 1) - RES_W'(K_BITS);
  endfunction

endpackage

// File: rtl/xnor_conv_sched_if.sv
// Activation and result streams of the XNOR convolution scheduler.
interface xnor_conv_sched_if;
  import xnor_pkg::*;

  logic              act_valid;
  logic              act_ready;
  logic [K_BITS-1:0] act_data;
  logic              res_valid;
  logic              res_ready;
  logic [RES_W-1:0]  res_data;
  logic              res_bit;
  logic              res_last;

  modport slave (
    input  act_valid, act_data, res_ready,
    output act_ready, res_valid, res_data, res_bit, res_last
  );

  modport master (
    output act_valid, act_data, res_ready,
    input  act_ready, res_valid, res_data, res_bit, res_last
  );

endinterface

// File: rtl/xnor_conv_sched_res_fifo.sv
// Synchronous result FIFO with occupancy count; push and pop may coincide,
// including a push into a full FIFO that is popped in the same cycle.
module xnor_res_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 9,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/xnor_conv_sched.sv
// Job sequencer for one XNOR popcount PE: latches the kernel, streams windows
// under credit flow control and buffers signed/thresholded results.
//
// state     | meaning
// ST_IDLE   | waiting for start; kernel and window count latched on start
// ST_SETTLE | one cycle for pe_in_b to settle at the PE
// ST_STREAM | issuing windows while credits remain
// ST_DRAIN  | waiting for the last result to be consumed
// ST_DONE   | one-cycle done pulse
module xnor_conv_sched
  import xnor_pkg::*;
#(
  parameter int NW_W      = 16,
  parameter int PE_LAT    = 1,
  parameter int OUT_DEPTH = 4,
  parameter int THRESH    = 13
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NW_W-1:0]      num_windows,
  input  logic [K_BITS-1:0]    weight_in,
  output logic                 busy,
  output logic                 done,
  xnor_conv_sched_if.slave     io,
  output logic [K_BITS-1:0]    pe_in_a,
  output logic [K_BITS-1:0]    pe_in_b,
  input  logic [CNT_W-1:0]     pe_out_c
);

  localparam int FCW   = $clog2(OUT_DEPTH + 1);
  localparam int IFW   = $clog2(PE_LAT + 2);
  localparam int OCCW  = $clog2(OUT_DEPTH + PE_LAT + 2);
  localparam int ENT_W = RES_W + 2;

  state_t            state_q, state_d;
  logic [NW_W-1:0]   nw_q, nw_d;
  logic [NW_W-1:0]   issued_q, issued_d;
  logic [K_BITS-1:0] pe_a_q, pe_a_d;
  logic [K_BITS-1:0] pe_b_q, pe_b_d;
  logic [PE_LAT:0]   pipe_vld_q, pipe_vld_d;
  logic [PE_LAT:0]   pipe_last_q, pipe_last_d;

  logic [FCW-1:0]    fifo_count;
  logic [IFW-1:0]    inflight;
  logic [OCCW-1:0]   occupancy;
  logic              act_rdy, act_hs, is_last_issue;
  logic              res_vld, res_hs, head_last;
  logic [ENT_W-1:0]  push_ent, head_ent;
  logic [RES_W-1:0]  clamp_c;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= PE_LAT; i++) inflight = inflight + IFW'(pipe_vld_q[i]);
  end

  // Credits count both buffered results and tags still travelling through the PE.
  assign occupancy     = OCCW'(fifo_count) + OCCW'(inflight);
  assign is_last_issue = (issued_q == nw_q - 1'b1);

  assign res_vld   = (fifo_count != '0);
  assign res_hs    = res_vld && io.res_ready;
  assign head_last = head_ent[0];

  always_comb begin
    state_d     = state_q;
    nw_d        = nw_q;
    issued_d    = issued_q;
    pe_a_d      = pe_a_q;
    pe_b_d      = pe_b_q;
    act_rdy     = 1'b0;
    act_hs      = 1'b0;
    pipe_vld_d  = '0;
    pipe_last_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nw_d     = num_windows;
          pe_b_d   = weight_in;
          issued_d = '0;
          state_d  = (num_windows == '0) ? ST_DONE : ST_SETTLE;
        end
      end
      ST_SETTLE: state_d = ST_STREAM;
      ST_STREAM: begin
        act_rdy = (issued_q < nw_q) && (occupancy < OCCW'(OUT_DEPTH));
        act_hs  = act_rdy && io.act_valid;
        if (act_hs) begin
          pe_a_d   = io.act_data;
          issued_d = issued_q + 1'b1;
          if (is_last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (res_hs && head_last && (inflight == '0)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    pipe_vld_d[0]  = act_hs;
    pipe_last_d[0] = act_hs && is_last_issue;
    for (int i = 1; i <= PE_LAT; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      nw_q        <= '0;
      issued_q    <= '0;
      pe_a_q      <= '0;
      pe_b_q      <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      state_q     <= state_d;
      nw_q        <= nw_d;
      issued_q    <= issued_d;
      pe_a_q      <= pe_a_d;
      pe_b_q      <= pe_b_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
    end
  end

  assign clamp_c  = pop_clamp(pe_out_c);
  assign push_ent = {pop_to_dot(pe_out_c), (clamp_c >= RES_W'(THRESH)), pipe_last_q[PE_LAT]};

  xnor_res_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (ENT_W)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (pipe_vld_q[PE_LAT]),
    .wdata (push_ent),
    .pop   (res_hs),
    .rdata (head_ent),
    .count (fifo_count)
  );

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign pe_in_a      = pe_a_q;
  assign pe_in_b      = pe_b_q;
  assign io.act_ready = act_rdy;
  assign io.res_valid = res_vld;
  assign io.res_data  = res_vld ? head_ent[ENT_W-1:2] : '0;
  assign io.res_bit   = res_vld && head_ent[1];
  assign io.res_last  = res_vld && head_last;

endmodule

// File: tb/tb_xnor_conv_sched.sv
// Self-checking bench for xnor_conv_sched: registered XNOR-popcount PE model,
// scoreboard filled on activation handshakes and drained on result handshakes.
module tb_xnor_conv_sched;
  import xnor_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] num_windows;
  logic [24:0] weight_in;
  logic        busy, done;
  logic [24:0] pe_in_a, pe_in_b;
  logic [5:0]  pe_out_c;

  xnor_conv_sched_if io();

  xnor_conv_sched #(
    .NW_W(16), .PE_LAT(1), .OUT_DEPTH(4), .THRESH(13)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_windows(num_windows),
    .weight_in(weight_in), .busy(busy), .done(done), .io(io),
    .pe_in_a(pe_in_a), .pe_in_b(pe_in_b), .pe_out_c(pe_out_c)
  );

  always #5 clk = ~clk;

  logic       pe_force_en = 1'b0;
  logic [5:0] pe_force_val = '0;
  always @(posedge clk)
    pe_out_c <= pe_force_en ? pe_force_val : 6'($countones(~(pe_in_a ^ pe_in_b)));

  typedef struct {
    logic [6:0] data;
    logic       b;
    logic       last;
  } exp_t;

  exp_t        exp_q[$];
  logic [24:0] wins[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cur_nw, iss_cnt, res_seen;
  logic [24:0] cur_w;
  bit          done_chk_pend = 0;
  bit          ready_seen = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   c;
    if (done_chk_pend) begin
      chk_eq("done_after_last", 32'(done), 32'd1);
      done_chk_pend = 0;
    end
    if (io.act_ready === 1'b1) ready_seen = 1;
    if (reset_n && io.act_valid && io.act_ready) begin
      c = pe_force_en ? int'(pe_force_val) : $countones(~(io.act_data ^ cur_w));
      if (c > 25) c = 25;
      e.data = 7'(2 * c - 25);
      e.b    = (c >= 13);
      e.last = (iss_cnt == cur_nw - 1);
      exp_q.push_back(e);
      iss_cnt++;
    end
    if (reset_n && io.res_valid && io.res_ready) begin
      if (exp_q.size() == 0) begin
        chk_eq("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk_eq("res_data", 32'(io.res_data), 32'(e.data));
        chk_eq("res_bit", 32'(io.res_bit), 32'(e.b));
        chk_eq("res_last", 32'(io.res_last), 32'(e.last));
        res_seen++;
        if (io.res_last) done_chk_pend = 1;
      end
    end
  end

  task automatic send_window(input logic [24:0] w, output int waited);
    int n = 0;
    io.act_valid = 1'b1;
    io.act_data  = w;
    @(negedge clk);
    while (io.act_ready !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    waited = n;
    if (n >= 300) chk_eq("act_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    io.act_valid = 1'b0;
    chk_eq("pe_in_a_update", 32'(pe_in_a), 32'(w));
  endtask

  task automatic run_job(input int nw, input logic [24:0] w, input int bp, input bit glitch);
    int          waited;
    int          n;
    logic [24:0] a_before;
    cur_nw = nw; cur_w = w; iss_cnt = 0; res_seen = 0; ready_seen = 0;
    a_before = pe_in_a;
    io.res_ready = (bp == 0);
    if (bp > 0) fork
      begin
        repeat (bp) @(posedge clk);
        #1;
        chk_eq("bp_accepted", 32'(iss_cnt), 32'd4);
        chk_eq("bp_no_result", 32'(res_seen), 32'd0);
        io.res_ready = 1'b1;
      end
    join_none
    if (glitch) fork
      begin
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; num_windows = 16'd2; weight_in = ~w;
        @(posedge clk); #1;
        start = 1'b0;
        chk_eq("glitch_pe_in_b", 32'(pe_in_b), 32'(w));
        chk_eq("glitch_busy", 32'(busy), 32'd1);
      end
    join_none

    @(posedge clk); #1;
    start = 1'b1; num_windows = 16'(nw); weight_in = w;
    io.act_valid = (nw > 0);
    io.act_data  = (nw > 0) ? wins[0] : '0;
    @(negedge clk);
    chk_eq("c0_act_ready", 32'(io.act_ready), 32'd0);
    chk_eq("c0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk_eq("c1_act_ready", 32'(io.act_ready), 32'd0);
    chk_eq("c1_pe_in_b", 32'(pe_in_b), 32'(w));
    chk_eq("c1_busy", 32'(busy), 32'd1);
    chk_eq("c1_done", 32'(done), 32'(nw == 0));

    if (nw == 0) begin
      @(negedge clk);
      chk_eq("zero_c2_done", 32'(done), 32'd0);
      chk_eq("zero_c2_busy", 32'(busy), 32'd0);
      chk_eq("zero_act_ready_seen", 32'(ready_seen), 32'd0);
      chk_eq("zero_pe_in_a", 32'(pe_in_a), 32'(a_before));
    end else begin
      @(posedge clk); #1;
      for (int i = 0; i < nw; i++) begin
        send_window(wins[i], waited);
        if (i == 0) chk_eq("first_hs_cycle2", 32'(waited), 32'd0);
        else if (bp == 0) chk_eq("back_to_back", 32'(waited), 32'd0);
      end
      n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 500) begin
        n++;
        @(negedge clk);
      end
      chk_eq("done_seen", 32'(done), 32'd1);
      chk_eq("result_count", 32'(res_seen), 32'(nw));
      chk_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk_eq("post_done_pulse", 32'(done), 32'd0);
      chk_eq("post_done_busy", 32'(busy), 32'd0);
    end
    io.res_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [24:0] w;
    reset_n = 1'b0; start = 1'b0; num_windows = '0; weight_in = '0;
    io.act_valid = 1'b0; io.act_data = '0; io.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_act_ready", 32'(io.act_ready), 32'd0);
    chk_eq("rst_res_valid", 32'(io.res_valid), 32'd0);
    chk_eq("rst_res_data", 32'(io.res_data), 32'd0);
    chk_eq("rst_res_bit", 32'(io.res_bit), 32'd0);
    chk_eq("rst_res_last", 32'(io.res_last), 32'd0);
    chk_eq("rst_pe_in_a", 32'(pe_in_a), 32'd0);
    chk_eq("rst_pe_in_b", 32'(pe_in_b), 32'd0);
    reset_n = 1'b1;

    // basic sequence: expected +25, -25, +1, -23 / bits 1,0,1,0
    wins = '{25'h1FFFFFF, 25'h0, 25'h1555555, 25'h1};
    run_job(4, 25'h1FFFFFF, 0, 0);

    // threshold edge: c = 12 then c = 13 with an all-zero kernel
    wins = '{25'h1FFF000, 25'h1FFE000};
    run_job(2, 25'h0, 0, 0);

    // backpressure: results held off for 20 cycles
    wins.delete();
    for (int i = 0; i < 10; i++) wins.push_back(25'($urandom));
    run_job(10, 25'($urandom), 20, 0);

    // zero-window job
    wins.delete();
    run_job(0, 25'h0ABCDEF, 0, 0);

    // start pulsed during STREAM must be ignored
    for (int i = 0; i < 6; i++) wins.push_back(25'($urandom));
    run_job(6, 25'($urandom), 0, 1);

    // popcount above 25 clamps to 25
    pe_force_en = 1'b1; pe_force_val = 6'd26;
    wins = '{25'h0, 25'h1, 25'h2};
    run_job(3, 25'h0, 0, 0);
    pe_force_val = 6'd63;
    run_job(3, 25'h1F, 0, 0);
    pe_force_en = 1'b0;

    // reset in mid-STREAM, then a clean job
    wins.delete();
    for (int i = 0; i < 8; i++) wins.push_back(25'($urandom));
    w = 25'($urandom);
    cur_nw = 8; cur_w = w; iss_cnt = 0; io.res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; num_windows = 16'd8; weight_in = w;
    io.act_valid = 1'b1; io.act_data = wins[0];
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk_eq("pre_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_eq("midrst_busy", 32'(busy), 32'd0);
    chk_eq("midrst_done", 32'(done), 32'd0);
    chk_eq("midrst_act_ready", 32'(io.act_ready), 32'd0);
    chk_eq("midrst_res_valid", 32'(io.res_valid), 32'd0);
    chk_eq("midrst_res_data", 32'(io.res_data), 32'd0);
    chk_eq("midrst_res_bit", 32'(io.res_bit), 32'd0);
    chk_eq("midrst_res_last", 32'(io.res_last), 32'd0);
    chk_eq("midrst_pe_in_a", 32'(pe_in_a), 32'd0);
    chk_eq("midrst_pe_in_b", 32'(pe_in_b), 32'd0);
    io.act_valid = 1'b0;
    @(negedge clk);
    exp_q.delete();
    done_chk_pend = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    wins.delete();
    for (int i = 0; i < 5; i++) wins.push_back(25'($urandom));
    run_job(5, 25'($urandom), 0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xnor_conv_sched.md
# xnor_conv_sched

Sequencer and flow controller for a single XNORconvSingle PE. It latches one 25-bit binary 5×5 kernel and applies it to the PE's weight input. It then holds one settle cycle before any activation is issued, and streams a programmed number of 25-bit activation windows into the PE. Each 6-bit popcount result is collected, converted to a signed ±1 dot product and a thresholded activation bit, and buffered for a backpressured result consumer.

## Interface
- `K_BITS`, 25: kernel/window width in bits.
- `CNT_W`, 6: PE popcount width.
- `NW_W`, 16: width of window count.
- `PE_LAT`, 1: PE latency, in cycles, from a `pe_in_a` update to a valid `pe_out_c`.
- `OUT_DEPTH`, 4: result FIFO depth; must be ≥ `PE_LAT`+1.
- `THRESH`, 13: `res_bit` = 1 when the clamped popcount ≥ `THRESH`.

Ports:
- `clk`, in, 1: single clock; all state is updated on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: job request; sampled only in IDLE.
- `num_windows`, in, `NW_W`: number of windows in the job; latched on `start`.
- `weight_in`, in, `K_BITS`: kernel; latched on `start`.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse at job completion.
- `act_valid`, in, 1: activation stream valid.
- `act_ready`, out, 1: activation stream ready.
- `act_data`, in, `K_BITS`: activation window.
- `pe_in_a`, out, `K_BITS`: registered window driven to the PE.
- `pe_in_b`, out, `K_BITS`: registered kernel driven to the PE.
- `pe_out_c`, in, `CNT_W`: PE popcount.
- `res_valid`, out, 1: result stream valid.
- `res_ready`, in, 1: result stream ready.
- `res_data`, out, 7: signed dot product.
- `res_bit`, out, 1: binarized activation.
- `res_last`, out, 1: marks the final result of the job.

## Operation
- FSM states are IDLE, SETTLE, STREAM, DRAIN and DONE.
- **IDLE:**
  - On `start`=1, latch `num_windows` and `weight_in`, and load `pe_in_b` ← `weight_in`.
  - If `num_windows`=0, go to DONE; otherwise go to SETTLE.
- **SETTLE:**
  - Lasts exactly 1 cycle.
  - `act_ready`=0 throughout.
  - Next state is STREAM.
- **STREAM:**
  - `act_ready` = (`issued` < `num_windows`) && (`credits` > 0), where `credits` = `OUT_DEPTH` − `fifo_count` − `inflight`.
  - On an activation handshake, `pe_in_a` ← `act_data`, `issued`++, and a tag enters a `PE_LAT`+1-deep valid shift pipe.
  - The tag carries `last` = (`issued` == `num_windows`−1).
  - When `issued` reaches `num_windows`, go to DRAIN.
- **DRAIN:**
  - `act_ready`=0.
  - Stay until `inflight`=0, the FIFO is empty, and the last result has been popped; then go to DONE.
- **DONE:**
  - `done`=1 for 1 cycle, then go to IDLE.
- **Result capture:**
  - When a tag exits the pipe, sample `pe_out_c` and push it into the FIFO.
  - The credit scheme guarantees a push never meets a full FIFO.
  - The FIFO stores {`res_data`, `res_bit`, `last`}.
- **Arithmetic:**
  - c = min(`pe_out_c`, 25).
  - `res_data` = 2·c − 25, in 7-bit two's complement, range −25..+25.
  - `res_bit` = (c ≥ `THRESH`).
- `pe_in_b` holds for the whole job and changes only on an accepted `start`. `pe_in_a` holds its last value between issues.
- `start` outside IDLE is ignored.
- Asynchronous reset mid-job aborts the job: in-flight tags and FIFO contents are discarded, and the FSM returns to IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `act_ready`=0, `res_valid`=0, `res_data`=0, `res_bit`=0, `res_last`=0, `pe_in_a`=0, `pe_in_b`=0. All counters and the FIFO are cleared.
- Let `start` be accepted at cycle 0. Then `pe_in_b` is valid at cycle 1 (SETTLE), and the earliest `act_ready`=1 is at cycle 2.
- Let an activation handshake occur at cycle t. Then `pe_in_a` updates at t+1, and `pe_out_c` is sampled at t+1+`PE_LAT`. With an empty FIFO, `res_valid` rises at t+2+`PE_LAT`.
- With `res_ready` held at 1, throughput is one window per cycle.
- A FIFO push and pop in the same cycle leave `fifo_count` unchanged. A full FIFO with `res_ready`=1 may accept a push in that same cycle.
- For a zero-window job, `done` pulses at cycle 1; `busy` is high for cycle 1 only, and no PE activity occurs.
- `done` is asserted the cycle after the handshake of the `res_last` result.

## Structure
- Package `xnor_pkg` holds:
  - constants `K_BITS` and `CNT_W`;
  - the FSM state enum;
  - function `pop_to_dot(c)`, which performs the clamp and the 2c−25 conversion.
- One sub-module, `xnor_res_fifo`: a synchronous FIFO with `DEPTH`/`WIDTH` parameters, async active-low reset, and count output.
- The PE instance lives in the parent, not in this block.

## Test plan
- `weight_in`=0x1FFFFFF, `num_windows`=4, windows 0x1FFFFFF, 0, 0x1555555, 1:
  - required `res_data` sequence +25, −25, +1, −23;
  - required `res_bit` sequence 1, 0, 1, 0;
  - `res_last` only on the 4th result.
- SETTLE rule: `act_valid` held at 1 from cycle 0:
  - `act_ready`=0 at cycles 0–1;
  - first handshake at cycle 2;
  - `pe_in_b` already stable at cycle 1.
- Backpressure: 10 windows with `res_ready`=0 for 20 cycles:
  - at most `OUT_DEPTH`=4 windows are accepted;
  - no result is lost;
  - after release, all 10 results arrive in order.
- `num_windows`=0:
  - `done` pulses at cycle 1;
  - `act_ready` never rises;
  - `pe_in_a` stays unchanged.
- `reset_n` low for 1 cycle in mid-STREAM:
  - all outputs return immediately to reset values;
  - a new `start` runs a clean job with correct results.
- `start` pulsed during STREAM: ignored; `num_windows` and `pe_in_b` are unchanged.
